voq_tx_ctrl: RTL and testbench

- Per-ingress-port VOQ transmit controller: the responder side of the crossbar scheduler handshake.
- Holds packet descriptors for 4 VOQs, one per egress port.
- Reports is_busy, busy_voq_num and voq_empty to the scheduler, accepts this ingress's grant slice, and streams the granted packet's words to the crossbar in fixed-size time slots.
- Four instances, one per ingress, sit between the ingress packet buffers and the crossbar.

---
 rtl/voq_tx_if.sv | 42 ++++
 rtl/voq_tx_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_voq_tx_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/voq_tx_if.sv
// Scheduler/ingress/crossbar handshake bundle for one VOQ transmit controller.
// The master side is the scheduler, the packet buffer and the crossbar.
// The slave side is voq_tx_ctrl.
interface voq_tx_if #(
    parameter int NUM_VOQ = 4,
    parameter int LEN_W   = 8
);
    // Descriptor enqueue from the ingress packet buffer
    logic               enq_valid;
    logic [1:0]         enq_voq;
    logic [LEN_W-1:0]   enq_len;
    logic               enq_drop;

    // Status reported to the scheduler
    logic [NUM_VOQ-1:0] voq_empty;
    logic               is_busy;
    logic [1:0]         busy_voq_num;

    // Grant slice for this ingress
    logic               sched_sel_en;
    logic               sched_sel_vld;
    logic [1:0]         sched_sel;
    logic               err_grant;

    // Word stream towards the crossbar
    logic               tx_valid;
    logic [1:0]         tx_voq;
    logic               tx_sop;
    logic               tx_eop;

    modport master (
        output enq_valid, enq_voq, enq_len, sched_sel_en, sched_sel_vld, sched_sel,
        input  enq_drop, voq_empty, is_busy, busy_voq_num, err_grant,
               tx_valid, tx_voq, tx_sop, tx_eop
    );

    modport slave (
        input  enq_valid, enq_voq, enq_len, sched_sel_en, sched_sel_vld, sched_sel,
        output enq_drop, voq_empty, is_busy, busy_voq_num, err_grant,
               tx_valid, tx_voq, tx_sop, tx_eop
    );
endinterface

// File: rtl/voq_tx_ctrl.sv
// Per-ingress VOQ transmit controller.
// It keeps a small descriptor FIFO for each egress VOQ and answers the
// scheduler's grants. It streams the granted packet in time slots of at most
// SLOT_WORDS words, and a packet longer than one slot is parked in HOLD until
// the same VOQ is granted again.
module voq_tx_ctrl #(
    parameter int NUM_VOQ    = 4,
    parameter int LEN_W      = 8,
    parameter int DESC_DEPTH = 4,
    parameter int SLOT_WORDS = 4
) (
    input logic    clk,
    input logic    rst_n,
    voq_tx_if.slave bus
);
    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(SLOT_WORDS);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DESC_DEPTH);
    localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_WORDS - 1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Descriptor FIFOs
    // ------------------------------------------------------------------
    logic [LEN_W-1:0] desc_mem [NUM_VOQ][DESC_DEPTH];
    logic [PTR_W-1:0] wr_ptr   [NUM_VOQ];
    logic [PTR_W-1:0] rd_ptr   [NUM_VOQ];
    logic [CNT_W-1:0] count    [NUM_VOQ];

    logic [NUM_VOQ-1:0] voq_empty_c;
    logic [NUM_VOQ-1:0] push_hit;
    logic [NUM_VOQ-1:0] pop_hit;
    logic               enq_ok;
    logic               pop;
    logic [LEN_W-1:0]   head_len;

    // ------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [SC_W-1:0]  slot_cnt, slot_nxt;
    logic [1:0]       busy_voq, busy_voq_nxt;
    logic             sop_nxt;
    logic             err_nxt;
    logic             grant;

    logic             is_busy_q;
    logic             tx_valid_q;
    logic [1:0]       tx_voq_q;
    logic             tx_sop_q;
    logic             tx_eop_q;
    logic             err_grant_q;
    logic             enq_drop_q;

    // A VOQ is reported empty exactly when its FIFO holds nothing; the
    // descriptor of the packet in flight has already been popped.
    always_comb begin
        for (int v = 0; v < NUM_VOQ; v++) begin
            voq_empty_c[v] = (count[v] == '0);
        end
    end

    assign head_len = desc_mem[bus.sched_sel][rd_ptr[bus.sched_sel]];
    assign grant    = bus.sched_sel_en && bus.sched_sel_vld;

    // A full FIFO can still take a descriptor when its head is popped in the
    // same cycle; zero-length packets are never queued.
    always_comb begin
        enq_ok = bus.enq_valid && (bus.enq_len != '0) &&
                 ((count[bus.enq_voq] != FULL_CNT) ||
                  (pop && (bus.sched_sel == bus.enq_voq)));
    end

    // Decode the push/pop strobes into per-VOQ hit vectors.
    always_comb begin
        // NOTE: every variable written here is given a value before any branch,
        // so no path can leave it unassigned and infer a latch.
        push_hit = '0;
        pop_hit  = '0;
        if (enq_ok) push_hit[bus.enq_voq]   = 1'b1;
        if (pop)    pop_hit[bus.sched_sel]  = 1'b1;
    end

    // Descriptor storage. A slot is only read after its count makes it
    // visible, so the contents need no initial value.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; only the
        // pointers and counts that qualify it are cleared.
        if (enq_ok) begin
            desc_mem[bus.enq_voq][wr_ptr[bus.enq_voq]] <= bus.enq_len;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap modulo DESC_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOQ; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOQ; v++) begin
                if (push_hit[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
                if (pop_hit[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
                case ({push_hit[v], pop_hit[v]})
                    2'b10:   count[v] <= count[v] + 1'b1;
                    2'b01:   count[v] <= count[v] - 1'b1;
                    default: count[v] <= count[v];
                endcase
            end
        end
    end

    // Grant handling and slot sequencing: next state, descriptor pop and the
    // values of the word that goes on the bus next cycle.
    always_comb begin
        // NOTE: combinational logic uses blocking '=', so later statements see
        // the defaults set above them; the registers below use '<=' only.
        state_nxt     = state;
        remaining_nxt = remaining;
        slot_nxt      = slot_cnt;
        busy_voq_nxt  = busy_voq;
        sop_nxt       = 1'b0;
        err_nxt       = 1'b0;
        pop           = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (!voq_empty_c[bus.sched_sel]) begin
                        pop           = 1'b1;
                        state_nxt     = TX;
                        remaining_nxt = head_len;
                        busy_voq_nxt  = bus.sched_sel;
                        slot_nxt      = '0;
                        sop_nxt       = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (grant) begin
                    if (bus.sched_sel == busy_voq) begin
                        state_nxt = TX;
                        slot_nxt  = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            TX: begin
                // The slot is already owned; a further grant is ignored.
                err_nxt       = grant;
                remaining_nxt = remaining - LEN_ONE;
                if (remaining == LEN_ONE) begin
                    state_nxt = IDLE;
                end else if (slot_cnt == SLOT_LAST) begin
                    state_nxt = HOLD;
                end else begin
                    slot_nxt = slot_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs. The tx_* registers are loaded from the
    // next-state values, so a word is on the bus during every cycle spent in
    // TX, and the first word follows the grant by exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            slot_cnt    <= '0;
            busy_voq    <= '0;
            is_busy_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_voq_q    <= '0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            err_grant_q <= 1'b0;
            enq_drop_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            remaining   <= remaining_nxt;
            slot_cnt    <= slot_nxt;
            busy_voq    <= busy_voq_nxt;
            is_busy_q   <= (state_nxt != IDLE);
            tx_valid_q  <= (state_nxt == TX);
            tx_voq_q    <= (state_nxt == TX) ? busy_voq_nxt : 2'd0;
            tx_sop_q    <= sop_nxt;
            tx_eop_q    <= (state_nxt == TX) && (remaining_nxt == LEN_ONE);
            err_grant_q <= err_nxt;
            enq_drop_q  <= bus.enq_valid && !enq_ok;
        end
    end

    assign bus.voq_empty    = voq_empty_c;
    assign bus.is_busy      = is_busy_q;
    assign bus.busy_voq_num = busy_voq;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.tx_voq       = tx_voq_q;
    assign bus.tx_sop       = tx_sop_q;
    assign bus.tx_eop       = tx_eop_q;
    assign bus.err_grant    = err_grant_q;
    assign bus.enq_drop     = enq_drop_q;

endmodule

// File: tb/tb_voq_tx_ctrl.sv
// Directed bench for voq_tx_ctrl. It applies a table of per-cycle vectors
// with hand-computed output snapshots. It then runs hand-written sequences
// for multi-slot packets, grants while a packet is held, and reset in the
// middle of a packet.
module tb_voq_tx_ctrl;
    logic clk;
    logic rst_n;

    voq_tx_if #(.NUM_VOQ(4), .LEN_W(8)) bus ();

    voq_tx_ctrl #(
        .NUM_VOQ   (4),
        .LEN_W     (8),
        .DESC_DEPTH(4),
        .SLOT_WORDS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ev;
        logic [1:0] evoq;
        logic [7:0] elen;
        logic       gen;
        logic       gvld;
        logic [1:0] gsel;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    int checks;
    int errors;
    int tot_words;
    int tot_sop;
    int eop_at;
    int bad_voq;
    int n;

    // Output snapshot:
    // {enq_drop, voq_empty[3:0], is_busy, busy_voq_num[1:0], tx_valid,
    //  tx_voq[1:0], tx_sop, tx_eop, err_grant}
    function automatic logic [13:0] mk_exp(input logic drop, input logic [3:0] empty,
                                           input logic busy, input logic [1:0] bvoq,
                                           input logic txv, input logic [1:0] txvoq,
                                           input logic sop, input logic eop,
                                           input logic err);
        return {drop, empty, busy, bvoq, txv, txvoq, sop, eop, err};
    endfunction

    function automatic logic [13:0] get_out();
        return {bus.enq_drop, bus.voq_empty, bus.is_busy, bus.busy_voq_num,
                bus.tx_valid, bus.tx_voq, bus.tx_sop, bus.tx_eop, bus.err_grant};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [1:0] evoq, input logic [7:0] elen,
                         input logic gen, input logic gvld, input logic [1:0] gsel);
        bus.enq_valid     = ev;
        bus.enq_voq       = evoq;
        bus.enq_len       = elen;
        bus.sched_sel_en  = gen;
        bus.sched_sel_vld = gvld;
        bus.sched_sel     = gsel;
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input string name, input logic ev, input logic [1:0] evoq,
                           input logic [7:0] elen, input logic gen, input logic gvld,
                           input logic [1:0] gsel, input logic [13:0] exp);
        vec_t v;
        v.name = name;
        v.ev   = ev;
        v.evoq = evoq;
        v.elen = elen;
        v.gen  = gen;
        v.gvld = gvld;
        v.gsel = gsel;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    // Issue one grant, then watch a fixed 6-cycle window, counting the words
    // of that slot and accumulating packet-level statistics.
    task automatic run_slot(input logic [1:0] sel, input logic [1:0] exp_voq, output int words);
        words = 0;
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b1, sel);
        step();
        drive_idle();
        for (int i = 0; i < 6; i++) begin
            if (bus.tx_valid) begin
                words++;
                tot_words++;
                if (bus.tx_sop) tot_sop++;
                if (bus.tx_eop) eop_at = tot_words;
                if (bus.tx_voq != exp_voq) bad_voq++;
            end
            step();
        end
    endtask

    localparam logic [13:0] RST_EXP = 14'b0_1111_0_00_0_00_0_0_0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        tot_words = 0;
        tot_sop   = 0;
        eop_at    = 0;
        bad_voq   = 0;

        // Table of single-cycle vectors. Each expected value is the output
        // snapshot sampled just after the edge that consumes the inputs.
        //       name              ev    voq   len    en    vld   sel    drop empty    busy bvoq  txv  txvoq sop  eop  err
        add_vec("idle",           1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1111, 0, 2'd0, 0, 2'd0, 0, 0, 0));
        add_vec("enq_v2_len3",    1'b1, 2'd2, 8'd3, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1011, 0, 2'd0, 0, 2'd0, 0, 0, 0));
        add_vec("grant_v2_w1",    1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd2, mk_exp(0, 4'b1111, 1, 2'd2, 1, 2'd2, 1, 0, 0));
        add_vec("v2_w2",          1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1111, 1, 2'd2, 1, 2'd2, 0, 0, 0));
        add_vec("v2_w3_eop",      1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1111, 1, 2'd2, 1, 2'd2, 0, 1, 0));
        add_vec("v2_done",        1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1111, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_v0_a",       1'b1, 2'd0, 8'd1, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1110, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_v0_b",       1'b1, 2'd0, 8'd2, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1110, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_v0_c",       1'b1, 2'd0, 8'd3, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1110, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_v0_d",       1'b1, 2'd0, 8'd4, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1110, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_full_drop",  1'b1, 2'd0, 8'd5, 1'b0, 1'b0, 2'd0, mk_exp(1, 4'b1110, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_len0_drop",  1'b1, 2'd1, 8'd0, 1'b0, 1'b0, 2'd0, mk_exp(1, 4'b1110, 0, 2'd2, 0, 2'd0, 0, 0, 0));
        add_vec("enq_pop_full",   1'b1, 2'd0, 8'd6, 1'b1, 1'b1, 2'd0, mk_exp(0, 4'b1110, 1, 2'd0, 1, 2'd0, 1, 1, 0));
        add_vec("v0_len1_done",   1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0, mk_exp(0, 4'b1110, 0, 2'd0, 0, 2'd0, 0, 0, 0));
        add_vec("count_kept_4",   1'b1, 2'd0, 8'd7, 1'b0, 1'b0, 2'd0, mk_exp(1, 4'b1110, 0, 2'd0, 0, 2'd0, 0, 0, 0));
        add_vec("grant_empty_v3", 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd3, mk_exp(0, 4'b1110, 0, 2'd0, 0, 2'd0, 0, 0, 1));
        add_vec("grant_no_vld",   1'b0, 2'd0, 8'd0, 1'b1, 1'b0, 2'd0, mk_exp(0, 4'b1110, 0, 2'd0, 0, 2'd0, 0, 0, 0));

        // Reset state
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("reset_state", get_out(), RST_EXP);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].evoq, vecs[i].elen, vecs[i].gen, vecs[i].gvld, vecs[i].gsel);
            step();
            check(vecs[i].name, get_out(), vecs[i].exp);
        end
        drive_idle();

        // Ten-word packet on voq1 split over three slots (4, 4, 2)
        drive(1'b1, 2'd1, 8'd10, 1'b0, 1'b0, 2'd0);
        step();
        drive_idle();
        check("v1_enq_empty", bus.voq_empty, 4'b1100);

        tot_words = 0;
        tot_sop   = 0;
        eop_at    = 0;
        bad_voq   = 0;
        run_slot(2'd1, 2'd1, n);
        check("slot1_words", n, 4);
        check("hold_busy", {bus.is_busy, bus.busy_voq_num}, {1'b1, 2'd1});
        check("hold_empty", bus.voq_empty, 4'b1110);

        // Grant to another VOQ while voq1 is held
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd3);
        step();
        drive_idle();
        check("hold_bad_grant", {bus.err_grant, bus.tx_valid, bus.is_busy}, 3'b101);
        step();
        check("hold_err_pulse", {bus.err_grant, bus.tx_valid, bus.is_busy}, 3'b001);

        run_slot(2'd1, 2'd1, n);
        check("slot2_words", n, 4);
        run_slot(2'd1, 2'd1, n);
        check("slot3_words", n, 2);
        check("pkt10_words", tot_words, 10);
        check("pkt10_sop", tot_sop, 1);
        check("pkt10_eop_at", eop_at, 10);
        check("pkt10_voq", bad_voq, 0);
        check("pkt10_idle", bus.is_busy, 1'b0);

        // Reset in the middle of a five-word packet on voq2
        drive(1'b1, 2'd2, 8'd5, 1'b0, 1'b0, 2'd0);
        step();
        drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 2'd2);
        step();
        drive_idle();
        check("rst_pkt_w1", {bus.tx_valid, bus.tx_sop, bus.tx_voq}, {1'b1, 1'b1, 2'd2});
        step();
        check("rst_pkt_w2", {bus.tx_valid, bus.tx_sop, bus.tx_voq}, {1'b1, 1'b0, 2'd2});
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", get_out(), RST_EXP);
        step();
        check("rst_held", get_out(), RST_EXP);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 2'd3, 8'd2, 1'b0, 1'b0, 2'd0);
        step();
        drive_idle();
        check("post_rst_enq", bus.voq_empty, 4'b0111);
        tot_words = 0;
        tot_sop   = 0;
        eop_at    = 0;
        bad_voq   = 0;
        run_slot(2'd3, 2'd3, n);
        check("post_rst_words", n, 2);
        check("post_rst_sop", tot_sop, 1);
        check("post_rst_eop_at", eop_at, 2);
        check("post_rst_voq", bad_voq, 0);
        check("post_rst_final", get_out(), mk_exp(0, 4'b1111, 0, 2'd3, 0, 2'd0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
